keypad_scanner: RTL and testbench

//  - Scans a 4x4 hex keypad, debounces presses and releases, and emits a 4-bit key code (0..F).
//  - Sits directly upstream of the calculator control FSM; tecla drives its 4-bit key input.
//  - tecla_valida marks exactly one new keystroke per physical press.

---
 rtl/keypad_pkg.sv | 41 ++++
 rtl/keypad_scanner_if.sv | 30 +++
 rtl/sync_2ff.sv | 35 +++
 rtl/keypad_scanner.sv | 155 +++++++++++++++
 tb/tb_keypad_scanner.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module : keypad_pkg
// Purpose: Shared types and constants for the 4x4 hex keypad scanner:
//          FSM state encoding, row/column index types, the key-code map,
//          and a helper that picks the lowest active (low) row.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  typedef logic [1:0] row_idx_t;
  typedef logic [1:0] col_idx_t;

  // Key code by [row][column].
  localparam logic [3:0] KEYMAP [0:3][0:3] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  // Rows are active-low; when several are low the lowest index wins.
  function automatic row_idx_t lowest_low(input logic [3:0] rows);
    row_idx_t r;
    if (!rows[0])      r = 2'd0;
    else if (!rows[1]) r = 2'd1;
    else if (!rows[2]) r = 2'd2;
    else               r = 2'd3;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scanner_if.sv
`default_nettype none
// ============================================================================
// Module : keypad_scanner_if
// Purpose: Bundles the keypad matrix lines and the key-code outputs.
// Ports  : linhas        rows from keypad, active-low
//          colunas       column drive, active-low, one-hot-zero
//          tecla         last accepted key code
//          tecla_valida  one-cycle pulse on a new key code
//          tecla_ativa   key held (acceptance until release debounced)
//          master = scanner side, slave = keypad/consumer side
// Rev    : 1.0  initial release
// ============================================================================
interface keypad_scanner_if;
  logic [3:0] linhas;
  logic [3:0] colunas;
  logic [3:0] tecla;
  logic       tecla_valida;
  logic       tecla_ativa;

  modport master (
    input  linhas,
    output colunas, tecla, tecla_valida, tecla_ativa
  );

  modport slave (
    output linhas,
    input  colunas, tecla, tecla_valida, tecla_ativa
  );
endinterface
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module : sync_2ff
// Purpose: Two-flop synchronizer for an asynchronous multi-bit level input.
//          Each bit is independent; reset value models the idle pull-ups.
// Ports  : clk  system clock
//          rst  asynchronous active-high reset
//          d    asynchronous input
//          q    synchronized output
// Rev    : 1.0  initial release
// ============================================================================
module sync_2ff #(
  parameter int         WIDTH     = 4,
  parameter logic [3:0] RESET_VAL = 4'hF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL[WIDTH-1:0];
      q    <= RESET_VAL[WIDTH-1:0];
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module : keypad_scanner
// Purpose: Scans a 4x4 hex keypad one column at a time, debounces press and
//          release of the detected key, and reports one key code per press.
// Ports  : clk   system clock
//          rst   asynchronous active-high reset
//          bus   keypad_scanner_if.master (linhas in; colunas, tecla,
//                tecla_valida, tecla_ativa out, all registered)
// Rev    : 1.0  initial release
// ============================================================================
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic                clk,
  input  logic                rst,
  keypad_scanner_if.master    bus
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  // The counter is compared one step early so that the transition happens
  // on the clock where it reaches DEBOUNCE_CYCLES-1; together with the
  // triggering cycle this gives DEBOUNCE_CYCLES consecutive stable clocks.
  localparam logic [DW-1:0] DEB_PRE  = DW'(DEBOUNCE_CYCLES - 2);

  logic [3:0] ls;

  sync_2ff #(.WIDTH(4), .RESET_VAL(4'hF)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.linhas),
    .q   (ls)
  );

  state_t        state, state_next;
  col_idx_t      idx, idx_next;
  col_idx_t      col, col_next;
  row_idx_t      row, row_next;
  logic [SW-1:0] scan_cnt, scan_cnt_next;
  logic [DW-1:0] deb_cnt, deb_cnt_next;
  logic [3:0]    colunas, colunas_next;
  logic [3:0]    tecla, tecla_next;
  logic          tecla_valida, tecla_valida_next;
  logic          tecla_ativa, tecla_ativa_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= SCAN;
      idx          <= 2'd0;
      col          <= 2'd0;
      row          <= 2'd0;
      scan_cnt     <= '0;
      deb_cnt      <= '0;
      colunas      <= 4'b1110;
      tecla        <= 4'h0;
      tecla_valida <= 1'b0;
      tecla_ativa  <= 1'b0;
    end else begin
      state        <= state_next;
      idx          <= idx_next;
      col          <= col_next;
      row          <= row_next;
      scan_cnt     <= scan_cnt_next;
      deb_cnt      <= deb_cnt_next;
      colunas      <= colunas_next;
      tecla        <= tecla_next;
      tecla_valida <= tecla_valida_next;
      tecla_ativa  <= tecla_ativa_next;
    end
  end

  always_comb begin
    state_next        = state;
    idx_next          = idx;
    col_next          = col;
    row_next          = row;
    scan_cnt_next     = scan_cnt;
    deb_cnt_next      = deb_cnt;
    tecla_next        = tecla;
    tecla_valida_next = 1'b0;
    tecla_ativa_next  = tecla_ativa;

    case (state)
      SCAN: begin
        if (scan_cnt == SCAN_LAST) begin
          scan_cnt_next = '0;
          if (ls != 4'b1111) begin
            // Freeze on this column; idx stays put so the drive holds.
            col_next     = idx;
            row_next     = lowest_low(ls);
            deb_cnt_next = '0;
            state_next   = DEBOUNCE;
          end else begin
            idx_next = idx + 2'd1;
          end
        end else begin
          scan_cnt_next = scan_cnt + 1'b1;
        end
      end

      DEBOUNCE: begin
        if (ls[row]) begin
          state_next    = SCAN;
          idx_next      = col + 2'd1;
          scan_cnt_next = '0;
        end else if (deb_cnt == DEB_PRE) begin
          deb_cnt_next      = deb_cnt + 1'b1;
          tecla_next        = KEYMAP[row][col];
          tecla_valida_next = 1'b1;
          tecla_ativa_next  = 1'b1;
          state_next        = PRESSED;
        end else begin
          deb_cnt_next = deb_cnt + 1'b1;
        end
      end

      PRESSED: begin
        if (ls[row]) begin
          deb_cnt_next = '0;
          state_next   = RELEASE;
        end
      end

      RELEASE: begin
        if (!ls[row]) begin
          deb_cnt_next = '0;
        end else if (deb_cnt == DEB_PRE) begin
          tecla_ativa_next = 1'b0;
          state_next       = SCAN;
          idx_next         = col + 2'd1;
          scan_cnt_next    = '0;
          deb_cnt_next     = '0;
        end else begin
          deb_cnt_next = deb_cnt + 1'b1;
        end
      end

      default: state_next = SCAN;
    endcase

    colunas_next = ~(4'b0001 << idx_next);
  end

  assign bus.colunas      = colunas;
  assign bus.tecla        = tecla;
  assign bus.tecla_valida = tecla_valida;
  assign bus.tecla_ativa  = tecla_ativa;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module : tb_keypad_scanner
// Purpose: Self-checking bench for keypad_scanner (SCAN_DIV=4,
//          DEBOUNCE_CYCLES=8) with a switch-matrix keypad model, a
//          cycle-level reference model and directed scenarios.
// Ports  : none
// Rev    : 1.0  initial release
// ============================================================================
module tb_keypad_scanner;

  localparam int SD  = 4;
  localparam int DEB = 8;

  logic clk;
  logic rst;
  logic [15:0] keys;  // keys[r*4+c] = pressed

  keypad_scanner_if kif ();

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (kif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Switch matrix: a row is pulled low when any pressed key on it sits on a
  // column currently driven low.
  always_comb begin
    kif.linhas = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !kif.colunas[c]) kif.linhas[r] = 1'b0;
  end

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [3:0] bkm [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                           4'h4, 4'h5, 4'h6, 4'hB,
                           4'h7, 4'h8, 4'h9, 4'hC,
                           4'hE, 4'h0, 4'hF, 4'hD};
  // mode: 0 scanning, 1 press being qualified, 2 held, 3 release qualifying
  int         mode, midx, mcol, mrow, dwell_left, left;
  logic [3:0] ms1, ms2, mls;
  logic [3:0] m_tecla;
  logic       m_val, m_ativa;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ms1 = 4'hF; ms2 = 4'hF;
      mode = 0; midx = 0; mcol = 0; mrow = 0;
      dwell_left = SD - 1; left = 0;
      m_tecla = 4'h0; m_val = 1'b0; m_ativa = 1'b0;
    end else begin
      mls = ms2; ms2 = ms1; ms1 = kif.linhas;
      m_val = 1'b0;
      case (mode)
        0: if (dwell_left == 0) begin
             dwell_left = SD - 1;
             if (mls != 4'hF) begin
               mcol = midx;
               for (int r = 3; r >= 0; r--) if (!mls[r]) mrow = r;
               left = DEB - 1;   // dwell cycle already counted as stable
               mode = 1;
             end else midx = (midx + 1) % 4;
           end else dwell_left--;
        1: if (mls[mrow]) begin
             mode = 0; midx = (mcol + 1) % 4; dwell_left = SD - 1;
           end else begin
             left--;
             if (left == 0) begin
               m_tecla = bkm[mrow*4+mcol]; m_val = 1'b1; m_ativa = 1'b1; mode = 2;
             end
           end
        2: if (mls[mrow]) begin mode = 3; left = DEB - 1; end
        default: if (!mls[mrow]) left = DEB - 1;
           else begin
             left--;
             if (left == 0) begin
               m_ativa = 1'b0; mode = 0; midx = (mcol + 1) % 4; dwell_left = SD - 1;
             end
           end
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  logic prev_val = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      check("colunas", kif.colunas, 4'hF ^ (4'b0001 << midx));
      check("tecla", kif.tecla, m_tecla);
      check("tecla_valida", {3'b0, kif.tecla_valida}, {3'b0, m_val});
      check("tecla_ativa", {3'b0, kif.tecla_ativa}, {3'b0, m_ativa});
      check("no_double_pulse", {3'b0, kif.tecla_valida & prev_val}, 4'h0);
      if (kif.tecla_valida) pulses++;
      prev_val = kif.tecla_valida;
    end else prev_val = 1'b0;
  end

  // ---------------- helpers ----------------
  task automatic wait_ativa(input logic lvl, input int max, output int n);
    n = 0;
    while (kif.tecla_ativa !== lvl && n < max) begin
      @(negedge clk); n++;
    end
    check("wait_tecla_ativa", {3'b0, kif.tecla_ativa}, {3'b0, lvl});
  endtask

  task automatic wait_col(input logic [3:0] cv, input int max);
    int n = 0;
    while (kif.colunas !== cv && n < max) begin
      @(negedge clk); n++;
    end
    check("wait_colunas", kif.colunas, cv);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_colunas"}, kif.colunas, 4'b1110);
    check({tag, "_tecla"}, kif.tecla, 4'h0);
    check({tag, "_valida"}, {3'b0, kif.tecla_valida}, 4'h0);
    check({tag, "_ativa"}, {3'b0, kif.tecla_ativa}, 4'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    logic [3:0] colseq [5];
    int n, p0;
    colseq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    keys = 16'h0;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

    // 1: idle scanning
    rst = 1'b0;
    for (int j = 0; j < 5; j++) begin
      check("idle_colseq", kif.colunas, colseq[j]);
      repeat (4) @(negedge clk);
    end
    repeat (12) @(negedge clk);
    check("idle_tecla", kif.tecla, 4'h0);
    check("idle_ativa", {3'b0, kif.tecla_ativa}, 4'h0);
    check("idle_pulses", 4'(pulses), 4'd0);

    // 2: hold r1/c1 for 60 clocks
    p0 = pulses;
    keys[5] = 1'b1;
    repeat (60) @(negedge clk);
    check("k5_ativa_held", {3'b0, kif.tecla_ativa}, 4'h1);
    check("k5_tecla", kif.tecla, 4'h5);
    keys[5] = 1'b0;
    wait_ativa(1'b0, 40, n);
    check("k5_resume_col2", kif.colunas, 4'b1011);
    check("k5_pulses", 4'(pulses - p0), 4'd1);

    // 3: short 3-clock press on r0/c3
    p0 = pulses;
    wait_col(4'b0111, 20);
    keys[3] = 1'b1;
    repeat (3) @(negedge clk);
    keys[3] = 1'b0;
    wait_col(4'b1110, 20);
    repeat (8) @(negedge clk);
    check("short_pulses", 4'(pulses - p0), 4'd0);
    check("short_tecla", kif.tecla, 4'h5);
    check("short_ativa", {3'b0, kif.tecla_ativa}, 4'h0);

    // 4: two keys in column 2, then r3/c3 alone
    p0 = pulses;
    keys[2] = 1'b1; keys[10] = 1'b1;
    repeat (40) @(negedge clk);
    check("multi_tecla", kif.tecla, 4'h3);
    keys[2] = 1'b0; keys[10] = 1'b0;
    wait_ativa(1'b0, 40, n);
    keys[15] = 1'b1;
    repeat (40) @(negedge clk);
    check("kd_tecla", kif.tecla, 4'hD);
    keys[15] = 1'b0;
    wait_ativa(1'b0, 40, n);
    check("multi_pulses", 4'(pulses - p0), 4'd2);

    // 5: one-clock glitch at release count 5
    p0 = pulses;
    keys[5] = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_pre_ativa", {3'b0, kif.tecla_ativa}, 4'h1);
    keys[5] = 1'b0;
    repeat (6) @(negedge clk);
    keys[5] = 1'b1;
    @(negedge clk);
    keys[5] = 1'b0;
    wait_ativa(1'b0, 40, n);
    check("glitch_release_clocks", 4'(n), 4'd9);
    check("glitch_pulses", 4'(pulses - p0), 4'd1);

    // 6: asynchronous reset while held
    keys[9] = 1'b1;
    wait_ativa(1'b1, 60, n);
    check("pre_rst_tecla", kif.tecla, 4'h8);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    p0 = pulses;
    n = 0;
    while (kif.tecla_valida !== 1'b1 && n < 60) begin
      @(negedge clk); n++;
    end
    check("post_rst_pulse", {3'b0, kif.tecla_valida}, 4'h1);
    check("post_rst_tecla", kif.tecla, 4'h8);
    repeat (10) @(negedge clk);
    keys[9] = 1'b0;
    wait_ativa(1'b0, 40, n);
    check("post_rst_pulses", 4'(pulses - p0), 4'd1);

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
